// File: rtl/hwpe_apb_periph_bridge.sv
// APB slave to HWPE peripheral-port bridge: one transaction in flight, with a
// timeout on both the grant and the response phase.
module hwpe_apb_periph_bridge #(
    parameter int unsigned          ID_WIDTH  = 16,
    parameter logic [ID_WIDTH-1:0]  BRIDGE_ID = '0,
    parameter int unsigned          TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [31:0]         paddr,
    input  logic [31:0]         pwdata,
    input  logic [3:0]          pstrb,
    output logic                pready,
    output logic                pslverr,
    output logic [31:0]         prdata,

    output logic                periph_req,
    input  logic                periph_gnt,
    output logic [31:0]         periph_add,
    output logic                periph_wen,
    output logic [3:0]          periph_be,
    output logic [31:0]         periph_data,
    output logic [ID_WIDTH-1:0] periph_id,

    input  logic                periph_r_valid,
    input  logic [31:0]         periph_r_data,
    input  logic [ID_WIDTH-1:0] periph_r_id
);

    localparam int unsigned CNT_W = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic              cnt_hit_c;
    logic              rsp_match_c;

    // Timeout fires in the cycle whose increment would make the count reach TIMEOUT.
    assign cnt_inc_c   = cnt_q + CNT_W'(1);
    assign cnt_hit_c   = (cnt_inc_c == CNT_W'(TIMEOUT));
    assign rsp_match_c = periph_r_valid && (periph_r_id == BRIDGE_ID);

    assign periph_id = BRIDGE_ID;

    // Transaction FSM; every APB and periph output is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pready      <= 1'b0;
            pslverr     <= 1'b0;
            prdata      <= '0;
            periph_req  <= 1'b0;
            periph_add  <= '0;
            periph_data <= '0;
            periph_be   <= '0;
            periph_wen  <= 1'b1;
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;

            case (state_q)
                IDLE: begin
                    if (psel && !penable) begin
                        periph_add  <= paddr;
                        periph_data <= pwdata;
                        periph_be   <= pwrite ? pstrb : 4'hF;
                        periph_wen  <= ~pwrite;
                        periph_req  <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= REQ;
                    end
                end

                REQ: begin
                    if (cnt_hit_c) begin
                        periph_req <= 1'b0;
                        pready     <= 1'b1;
                        pslverr    <= 1'b1;
                        state_q    <= DONE;
                    end else if (periph_gnt) begin
                        periph_req <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= RESP;
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end

                RESP: begin
                    if (cnt_hit_c) begin
                        pready  <= 1'b1;
                        pslverr <= 1'b1;
                        state_q <= DONE;
                    end else if (rsp_match_c) begin
                        // Write responses complete the transfer but return no data.
                        pready  <= 1'b1;
                        prdata  <= periph_wen ? periph_r_data : 32'h0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
